// File: rtl/nios_system_sysid_ext.sv
// System ID peripheral: ID/timestamp words, 64-bit uptime counter with HI snapshot,
// control register and lockable scratch registers behind a never-stalling read pipeline.
module nios_system_sysid_ext #(
  parameter logic [31:0] ID_VALUE     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h5662_6049,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned NUM_SCRATCH  = 4,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam logic [ADDR_W-1:0] AddrId    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] AddrTs    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrLo    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] AddrHi    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] AddrCtrl  = ADDR_W'(4);
  localparam int unsigned       ScratchBase = 5;

  logic [63:0] uptime_q, uptime_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic        en_q, en_d;
  logic        lock_q, lock_d;
  logic        ovf_q, ovf_d;

  logic [31:0] scratch_q [NUM_SCRATCH];
  logic [31:0] scratch_d [NUM_SCRATCH];

  logic [31:0]             pipe_data_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_vld_q;

  logic        rd_acc;
  logic        wr_ctrl;
  logic        clr;
  logic [31:0] lane_mask;
  logic [31:0] ctrl_word;
  logic [31:0] rd_mux;

  // A simultaneous read+write is a pure write.
  assign rd_acc    = read & ~write;
  assign wr_ctrl   = write & (address == AddrCtrl);
  assign lane_mask = {{8{byteenable[3]}}, {8{byteenable[2]}},
                      {8{byteenable[1]}}, {8{byteenable[0]}}};
  assign clr       = wr_ctrl & byteenable[0] & writedata[1];
  assign ctrl_word = {15'd0, ovf_q, 7'd0, lock_q, 7'd0, en_q};

  always_comb begin : ctrl_next
    en_d     = en_q;
    lock_d   = lock_q;
    ovf_d    = ovf_q;
    uptime_d = uptime_q;
    if (wr_ctrl && byteenable[0]) begin
      en_d = writedata[0];
    end
    if (wr_ctrl && byteenable[1] && writedata[8]) begin
      lock_d = 1'b1;
    end
    // Clear wins over a same-cycle increment or wrap.
    if (clr) begin
      uptime_d = '0;
      ovf_d    = 1'b0;
    end else if (en_q) begin
      uptime_d = uptime_q + 64'd1;
      if (&uptime_q) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_comb begin : shadow_next
    hi_shadow_d = hi_shadow_q;
    if (rd_acc && (address == AddrLo)) begin
      hi_shadow_d = uptime_q[63:32];
    end
  end

  always_comb begin : scratch_next
    for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
      scratch_d[i] = scratch_q[i];
      if (write && !lock_q && (32'(address) == 32'(ScratchBase + i))) begin
        scratch_d[i] = (scratch_q[i] & ~lane_mask) | (writedata & lane_mask);
      end
    end
  end

  always_comb begin : read_mux
    rd_mux = '0;
    case (address)
      AddrId:   rd_mux = ID_VALUE;
      AddrTs:   rd_mux = TIMESTAMP;
      AddrLo:   rd_mux = uptime_q[31:0];
      AddrHi:   rd_mux = hi_shadow_q;
      AddrCtrl: rd_mux = ctrl_word;
      default: begin
        for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
          if (32'(address) == 32'(ScratchBase + i)) begin
            rd_mux = scratch_q[i];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      uptime_q    <= '0;
      hi_shadow_q <= '0;
      en_q        <= 1'b0;
      lock_q      <= 1'b0;
      ovf_q       <= 1'b0;
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
        scratch_q[i] <= '0;
      end
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        pipe_data_q[i] <= '0;
      end
      pipe_vld_q <= '0;
    end else begin
      uptime_q    <= uptime_d;
      hi_shadow_q <= hi_shadow_d;
      en_q        <= en_d;
      lock_q      <= lock_d;
      ovf_q       <= ovf_d;
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
        scratch_q[i] <= scratch_d[i];
      end
      // Data is zeroed on invalid stages so readdata is 0 whenever the strobe is low.
      pipe_vld_q[0]  <= rd_acc;
      pipe_data_q[0] <= rd_acc ? rd_mux : '0;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  // Masking by reset discards a strobe that would land in a reset cycle.
  assign readdatavalid = pipe_vld_q[READ_LATENCY-1] & ~reset;
  assign readdata      = reset ? 32'd0 : pipe_data_q[READ_LATENCY-1];

endmodule

// File: tb/tb_nios_system_sysid_ext.sv
// Bench for nios_system_sysid_ext: table-driven register accesses plus hand sequences,
// with read expectations queued at issue time and matched against each strobe.
module tb_nios_system_sysid_ext;

  localparam int unsigned RL = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  nios_system_sysid_ext #(
    .ID_VALUE     (32'h0000_0000),
    .TIMESTAMP    (32'h5662_6049),
    .ADDR_W       (4),
    .NUM_SCRATCH  (4),
    .READ_LATENCY (RL)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] data;
    string       name;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
    string       name;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
  endtask

  // Strobe monitor: every strobe must match the oldest outstanding read, on time.
  always @(negedge clock) begin
    if (readdatavalid) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_strobe: got readdata 0x%08h at cycle %0d, required no strobe",
                 readdata, cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.due));
        check(mon_e.name, readdata, mon_e.data);
      end
    end else begin
      check("idle_readdata_zero", readdata, 32'd0);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        mon_e = sb.pop_front();
        checks++;
        $display("FAIL %s_missing: got no strobe at cycle %0d, required strobe with 0x%08h",
                 mon_e.name, cyc, mon_e.data);
      end
    end
  end

  task automatic apply(input logic rd, input logic wr, input logic [3:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp, input string name, input bit expect_rd);
    read       = rd;
    write      = wr;
    address    = addr;
    writedata  = wdata;
    byteenable = be;
    if (expect_rd && rd && !wr) sb.push_back('{cyc + RL, exp, name});
  endtask

  task automatic rd_reg(input logic [3:0] addr, input logic [31:0] exp, input string name);
    @(negedge clock);
    apply(1'b1, 1'b0, addr, 32'd0, 4'h0, exp, name, 1'b1);
  endtask

  task automatic wr_reg(input logic [3:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    @(negedge clock);
    apply(1'b0, 1'b1, addr, wdata, be, 32'd0, "", 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      apply(1'b0, 1'b0, 4'd0, 32'd0, 4'h0, 32'd0, "", 1'b0);
    end
  endtask

  task automatic add(input logic rd, input logic wr, input logic [3:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] exp, input string name);
    tbl.push_back('{rd, wr, addr, wdata, be, exp, name});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    apply(1'b0, 1'b0, 4'd0, 32'd0, 4'h0, 32'd0, "", 1'b0);

    add(1, 0, 4'd0,  32'h0,         4'h0,    32'h0000_0000, "id");
    add(1, 0, 4'd1,  32'h0,         4'h0,    32'h5662_6049, "timestamp");
    add(1, 0, 4'd4,  32'h0,         4'h0,    32'h0000_0000, "ctrl_after_reset");
    add(1, 0, 4'd3,  32'h0,         4'h0,    32'h0000_0000, "hi_after_reset");
    add(0, 1, 4'd5,  32'hDEAD_BEEF, 4'b0101, 32'h0,         "");
    add(1, 0, 4'd5,  32'h0,         4'h0,    32'h00AD_00EF, "scratch0_lanes");
    add(1, 1, 4'd6,  32'h1111_2222, 4'hF,    32'h0,         "");
    add(1, 0, 4'd6,  32'h0,         4'h0,    32'h1111_2222, "scratch1_rdwr_lands");
    add(0, 1, 4'd0,  32'hFFFF_FFFF, 4'hF,    32'h0,         "");
    add(1, 0, 4'd0,  32'h0,         4'h0,    32'h0000_0000, "id_ro");
    add(0, 1, 4'd8,  32'hA5A5_A5A5, 4'b1010, 32'h0,         "");
    add(1, 0, 4'd8,  32'h0,         4'h0,    32'hA500_A500, "scratch3_lanes");
    add(1, 0, 4'd9,  32'h0,         4'h0,    32'h0000_0000, "unmapped9");
    add(0, 1, 4'd9,  32'hFFFF_FFFF, 4'hF,    32'h0,         "");
    add(1, 0, 4'd9,  32'h0,         4'h0,    32'h0000_0000, "unmapped9_after_wr");
    add(1, 0, 4'd15, 32'h0,         4'h0,    32'h0000_0000, "unmapped15");
    add(0, 1, 4'd4,  32'h0000_0103, 4'b1100, 32'h0,         "");
    add(1, 0, 4'd4,  32'h0,         4'h0,    32'h0000_0000, "ctrl_lanes_off");
    add(1, 0, 4'd7,  32'h0,         4'h0,    32'h0000_0000, "scratch2_untouched");

    repeat (3) @(negedge clock);
    check("reset_readdatavalid", 32'(readdatavalid), 32'd0);
    check("reset_readdata", readdata, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clock);
      apply(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].exp,
            tbl[i].name, 1'b1);
    end
    idle(3);

    // Enable, let 10 cycles pass; LO then counts 10, HI snapshot is 0.
    wr_reg(4'd4, 32'h1, 4'b0001);
    idle(10);
    rd_reg(4'd2, 32'd10, "uptime_lo");
    rd_reg(4'd3, 32'd0, "uptime_hi");
    rd_reg(4'd4, 32'h1, "ctrl_en");

    // Preload near wrap; FE, FF then 0 with OVF.
    @(negedge clock);
    force dut.uptime_q = 64'hFFFF_FFFF_FFFF_FFFE;
    apply(1'b0, 1'b0, 4'd0, 32'd0, 4'h0, 32'd0, "", 1'b0);
    @(negedge clock);
    release dut.uptime_q;
    apply(1'b1, 1'b0, 4'd2, 32'd0, 4'h0, 32'hFFFF_FFFE, "lo_near_wrap", 1'b1);
    rd_reg(4'd3, 32'hFFFF_FFFF, "hi_snapshot");
    rd_reg(4'd4, 32'h0001_0001, "ctrl_ovf");
    wr_reg(4'd4, 32'h3, 4'b0001);
    rd_reg(4'd2, 32'd0, "lo_after_clr");
    rd_reg(4'd4, 32'h1, "ctrl_ovf_cleared");
    rd_reg(4'd3, 32'd0, "hi_after_clr");

    // Lock is set-only and blocks scratch writes.
    wr_reg(4'd4, 32'h100, 4'b0010);
    rd_reg(4'd4, 32'h101, "ctrl_lock");
    wr_reg(4'd5, 32'h1234_5678, 4'hF);
    rd_reg(4'd5, 32'h00AD_00EF, "scratch0_locked");
    wr_reg(4'd4, 32'h0, 4'hF);
    rd_reg(4'd4, 32'h100, "ctrl_lock_sticky");

    idle(2);
    @(negedge clock);
    reset = 1'b1;
    idle(2);
    @(negedge clock);
    reset = 1'b0;
    rd_reg(4'd5, 32'd0, "scratch0_after_reset");
    rd_reg(4'd4, 32'd0, "ctrl_after_reset2");
    wr_reg(4'd5, 32'hCAFE_F00D, 4'hF);
    rd_reg(4'd5, 32'hCAFE_F00D, "scratch0_unlocked");

    // Read in flight when reset asserts: it must never strobe; writes during reset are dropped.
    @(negedge clock);
    apply(1'b1, 1'b0, 4'd1, 32'd0, 4'h0, 32'd0, "", 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    apply(1'b0, 1'b1, 4'd5, 32'hFFFF_FFFF, 4'hF, 32'd0, "", 1'b0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    apply(1'b0, 1'b0, 4'd0, 32'd0, 4'h0, 32'd0, "", 1'b0);
    rd_reg(4'd5, 32'd0, "scratch0_reset_write_ignored");
    rd_reg(4'd1, 32'h5662_6049, "timestamp_after_reset");
    idle(4);

    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      $display("FAIL %s_never_strobed: got no strobe, required 0x%08h", mon_e.name, mon_e.data);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/nios_system_sysid_ext.md
NIOS_SYSTEM_SYSID_EXT -- requirements
Module: nios_system_sysid_ext

Interface
REQ-001 Parameters SHALL be as follows:
- ID_VALUE, default 32'h0000_0000, system ID word.
- TIMESTAMP, default 32'h5662_6049, build timestamp word.
- ADDR_W, default 4, word address width.
- NUM_SCRATCH, default 4, number of scratch registers; legal range 1..(2^ADDR_W - 5).
- READ_LATENCY, default 1, cycles from accepted read to readdatavalid; legal values 1 or 2.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1, sole clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-high reset.
- address, in, ADDR_W, word address.
- read, in, 1, read request.
- write, in, 1, write request.
- writedata, in, 32, write data.
- byteenable, in, 4, byte lanes for writes.
- readdata, out, 32, registered read data.
- readdatavalid, out, 1, one-cycle strobe qualifying readdata.
REQ-003 Clocking and reset are fixed: one clock, and reset is synchronous and active-high.
REQ-004 The block SHALL never stall; there is no waitrequest, and every request is accepted in the cycle it is presented.

Function
REQ-005 The register map SHALL be:
- 0 ID (RO)
- 1 TIMESTAMP (RO)
- 2 UPTIME_LO (RO)
- 3 UPTIME_HI (RO, snapshot)
- 4 CTRL
- 5..4+NUM_SCRATCH SCRATCH[i] (RW)
REQ-006 Unmapped addresses SHALL read 0, and writes to them SHALL be ignored; writes to RO registers SHALL also be ignored.
REQ-007 The 64-bit uptime counter SHALL increment by 1 every cycle while CTRL.EN=1 and hold its value while CTRL.EN=0.
REQ-008 Counter wrap from 2^64-1 to 0 SHALL set the sticky flag CTRL.OVF (bit 16, RO).
REQ-009 A read of UPTIME_LO SHALL:
- return counter bits [31:0] as sampled in the accept cycle;
- in the same cycle, load bits [63:32] into the HI shadow register.
REQ-010 A read of UPTIME_HI SHALL return the shadow register, never the live counter.
REQ-011 CTRL bit assignments SHALL be:
- bit0 EN (RW)
- bit1 CLR (write-1 pulse, reads 0)
- bit8 LOCK (RW, set-only)
- bit16 OVF (RO)
- all other bits read 0.
REQ-012 Writing CLR=1 SHALL zero the counter and OVF at the next edge; if CLR coincides with an increment or a wrap, the clear SHALL take priority.
REQ-013 LOCK SHALL be settable by a write of 1 and clearable only by reset; while LOCK=1, SCRATCH writes SHALL be ignored.
REQ-014 CTRL and SCRATCH writes SHALL honour byteenable per lane; CTRL bit0/bit1 take effect only when byteenable[0]=1, and bit8 only when byteenable[1]=1.
REQ-015 A write SHALL take effect at the edge ending its accept cycle, so a read in the next cycle observes the new value.
REQ-016 When read and write are asserted together, the request SHALL be treated as a write only, and no readdatavalid SHALL be generated.
REQ-017 Read timing SHALL be:
- readdatavalid asserted exactly READ_LATENCY cycles after an accepted read, for one cycle;
- back-to-back reads SHALL be supported every cycle, each producing its own strobe in order.
REQ-018 readdata SHALL be 0 in any cycle where readdatavalid=0.

Reset
REQ-019 While reset=1, the block SHALL clear all of the following at each edge:
- counter, HI shadow, EN, LOCK, OVF, all SCRATCH;
- all read-pipeline stages;
- readdata=0 and readdatavalid=0.
REQ-020 A read accepted within the last READ_LATENCY cycles before reset asserts SHALL be discarded, with no readdatavalid after reset releases.
REQ-021 Requests presented while reset=1 SHALL be ignored; the first edge after reset deasserts SHALL accept requests normally.

Verification
REQ-022 Read addresses 0 and 1 with default parameters -> readdata 0x00000000 and 0x56626049, each strobed after READ_LATENCY cycles.
REQ-023 Write CTRL=1, wait 10 cycles, read LO then HI -> LO within [10,12] depending on READ_LATENCY, HI=0; back-to-back reads yield consecutive strobes.
REQ-024 Force the counter to 0xFFFFFFFF_FFFFFFFE with EN=1 and read CTRL after 3 cycles -> OVF=1. Then write CTRL=0x3 -> the counter restarts from 0 and OVF=0.
REQ-025 Write SCRATCH0=0xDEADBEEF with byteenable=4'b0101 -> reads 0x00AD00EF.
- Then set LOCK and write 0x12345678 -> read is unchanged.
- Then reset -> read returns 0.
REQ-026 Assert read+write together to SCRATCH1 -> no readdatavalid and the write lands; a read of address 15 -> 0.
REQ-027 Issue a read, assert reset the next cycle, hold it 2 cycles -> readdatavalid never asserts.
